// File: rtl/conv_window_gen.sv
// conv_window_gen: turns a row-major single-channel pixel stream into 3x3
// windows ("valid" convolution, no padding) for the MAC array input.
// Two line buffers hold the previous two rows; a two-column register pair plus
// the freshly assembled column form the window. One window is emitted, with
// latency 1, for every accepted pixel at row >= 2 and col >= 2.
module conv_window_gen #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_W      = 32,
    parameter int IMG_H      = 32,
    parameter int WIN_NUM    = 9
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          start,
    input  logic [DATA_WIDTH-1:0]         pix_in,
    input  logic                          pix_valid_in,
    output logic [WIN_NUM*DATA_WIDTH-1:0] win_data_out,
    output logic                          win_valid_out,
    output logic                          frame_done,
    output logic                          busy
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t                        r_state;
    state_t                        w_state_nxt;
    logic [CW-1:0]                 r_col;
    logic [RW-1:0]                 r_row;
    logic [DATA_WIDTH-1:0]         r_lb1 [IMG_W];
    logic [DATA_WIDTH-1:0]         r_lb2 [IMG_W];
    logic [DATA_WIDTH-1:0]         r_c0  [3];
    logic [DATA_WIDTH-1:0]         r_c1  [3];
    logic [DATA_WIDTH-1:0]         w_new [3];
    logic [WIN_NUM*DATA_WIDTH-1:0] w_win;
    logic [WIN_NUM*DATA_WIDTH-1:0] r_win;
    logic                          r_valid;
    logic                          r_done;
    logic                          w_accept;
    logic                          w_last;
    logic                          w_emit;

    // State register.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state plus pixel-acceptance, emission and end-of-frame decode.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_last      = 1'b0;
        w_emit      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                // A start pulse drops the pixel of its own cycle.
                w_accept = pix_valid_in && !start;
                w_emit   = w_accept && (r_row >= ROW_TWO) && (r_col >= COL_TWO);
                w_last   = w_accept && (r_row == ROW_LAST) && (r_col == COL_LAST);
                if (w_last) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Column/row position of the next pixel to be accepted.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_col <= '0;
            r_row <= '0;
        end else if (start || w_last) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_accept) begin
            if (r_col == COL_LAST) begin
                r_col <= '0;
                r_row <= r_row + RW'(1);
            end else begin
                r_col <= r_col + CW'(1);
            end
        end
    end

    // Line buffers (read-before-write) and the two older window columns.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_lb1[r_col] <= pix_in;
            r_lb2[r_col] <= r_lb1[r_col];
            for (int unsigned r = 0; r < 3; r++) begin
                r_c0[r] <= r_c1[r];
                r_c1[r] <= w_new[r];
            end
        end
    end

    // Assemble the window: slot 3*r+c, r=0 top row, c=2 newest column.
    always_comb begin
        w_new[0] = r_lb2[r_col];
        w_new[1] = r_lb1[r_col];
        w_new[2] = pix_in;
        w_win    = '0;
        for (int unsigned r = 0; r < 3; r++) begin
            w_win[DATA_WIDTH*(3*r)   +: DATA_WIDTH] = r_c0[r];
            w_win[DATA_WIDTH*(3*r+1) +: DATA_WIDTH] = r_c1[r];
            w_win[DATA_WIDTH*(3*r+2) +: DATA_WIDTH] = w_new[r];
        end
    end

    // Output registers; window data holds between valid strobes.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_win   <= '0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_valid <= w_emit;
            r_done  <= w_last;
            if (w_emit) begin
                r_win <= w_win;
            end
        end
    end

    assign win_data_out  = r_win;
    assign win_valid_out = r_valid;
    assign frame_done    = r_done;
    assign busy          = (r_state == S_RUN);

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench for conv_window_gen: a 4x4 instance for hand-computed
// windows and a default 32x32 instance checked against an image array.
module tb_conv_window_gen;

    logic        clk;
    logic        rstn;
    logic        start4, valid4;
    logic [7:0]  pix4;
    logic [71:0] data4;
    logic        wv4, done4, busy4;
    logic        start32, valid32;
    logic [7:0]  pix32;
    logic [71:0] data32;
    logic        wv32, done32, busy32;

    int n_checks = 0;
    int n_err    = 0;

    logic [7:0] img [1024];

    conv_window_gen #(.DATA_WIDTH(8), .IMG_W(4), .IMG_H(4), .WIN_NUM(9)) dut4 (
        .clk(clk), .rstn(rstn), .start(start4), .pix_in(pix4),
        .pix_valid_in(valid4), .win_data_out(data4), .win_valid_out(wv4),
        .frame_done(done4), .busy(busy4)
    );

    conv_window_gen #(.DATA_WIDTH(8), .IMG_W(32), .IMG_H(32), .WIN_NUM(9)) dut32 (
        .clk(clk), .rstn(rstn), .start(start32), .pix_in(pix32),
        .pix_valid_in(valid32), .win_data_out(data32), .win_valid_out(wv32),
        .frame_done(done32), .busy(busy32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Window of a 4x4 frame holding values 0..15, emitted after pixel n.
    function automatic logic [71:0] win4(input int n);
        logic [71:0] w;
        w = '0;
        for (int k = 0; k < 9; k++) begin
            w[8*k +: 8] = 8'(n - 10 + 4 * (k / 3) + (k % 3));
        end
        return w;
    endfunction

    task automatic step4(input logic st, input logic v, input logic [7:0] p);
        start4 = st;
        valid4 = v;
        pix4   = p;
        @(posedge clk);
        #1;
        start4 = 1'b0;
        valid4 = 1'b0;
    endtask

    task automatic do_start4(input logic [7:0] p);
        step4(1'b1, 1'b1, p);
        chk("start_busy4", busy4, 1'b1);
        chk("start_valid4", wv4, 1'b0);
        chk("start_done4", done4, 1'b0);
    endtask

    // Feed pixels 0..npix-1 of a 4x4 frame, optionally with a hole after each.
    task automatic frame4(input bit holes, input int npix);
        int  wins_obs;
        int  wins_exp;
        bit  ew;
        wins_obs = 0;
        wins_exp = 0;
        for (int i = 0; i < npix; i++) begin
            step4(1'b0, 1'b1, 8'(i));
            ew = (i == 10) || (i == 11) || (i == 14) || (i == 15);
            if (ew) wins_exp++;
            if (wv4) wins_obs++;
            chk("valid4", wv4, ew);
            if (ew) chk("win4", data4, win4(i));
            chk("done4", done4, (i == 15));
            chk("busy4", busy4, (i != 15));
            if (holes && i != 15) begin
                step4(1'b0, 1'b0, 8'hAA);
                if (wv4) wins_obs++;
                chk("hole_valid4", wv4, 1'b0);
                chk("hole_done4", done4, 1'b0);
            end
        end
        chk("count4", wins_obs, wins_exp);
    endtask

    initial begin
        int          wins32;
        int          dones32;
        int          r;
        int          c;
        bit          ew;
        logic [71:0] e;

        rstn = 1'b0;
        start4 = 1'b0; valid4 = 1'b0; pix4 = '0;
        start32 = 1'b0; valid32 = 1'b0; pix32 = '0;
        step4(1'b0, 1'b0, 8'h00);
        step4(1'b0, 1'b0, 8'h00);

        // Reset state of both instances.
        chk("rst_valid4", wv4, 1'b0);
        chk("rst_done4", done4, 1'b0);
        chk("rst_busy4", busy4, 1'b0);
        chk("rst_data4", data4, 72'h0);
        chk("rst_valid32", wv32, 1'b0);
        chk("rst_busy32", busy32, 1'b0);
        chk("rst_data32", data32, 72'h0);
        rstn = 1'b1;

        // IDLE filtering: pixels before start and in the start cycle dropped.
        for (int i = 0; i < 3; i++) begin
            step4(1'b0, 1'b1, 8'd99);
            chk("idle_busy4", busy4, 1'b0);
            chk("idle_valid4", wv4, 1'b0);
        end
        do_start4(8'd99);

        // Basic back-to-back frame.
        frame4(1'b0, 16);

        // Pixels after frame completion are ignored.
        for (int i = 0; i < 2; i++) begin
            step4(1'b0, 1'b1, 8'd77);
            chk("post_busy4", busy4, 1'b0);
            chk("post_valid4", wv4, 1'b0);
            chk("post_done4", done4, 1'b0);
        end

        // Frame with alternating holes.
        do_start4(8'd55);
        frame4(1'b1, 16);

        // Restart after 12 pixels; start drops pixel 12.
        do_start4(8'd55);
        frame4(1'b0, 12);
        do_start4(8'd12);
        frame4(1'b0, 16);

        // Start in the cycle right after the last pixel, then a new frame.
        do_start4(8'd44);
        frame4(1'b0, 16);

        // Mid-frame reset after pixel 10.
        do_start4(8'd33);
        frame4(1'b0, 11);
        rstn = 1'b0;
        step4(1'b0, 1'b1, 8'd11);
        rstn = 1'b1;
        chk("mrst_valid4", wv4, 1'b0);
        chk("mrst_busy4", busy4, 1'b0);
        chk("mrst_done4", done4, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step4(1'b0, 1'b1, 8'(12 + i));
            chk("mrst_idle_valid4", wv4, 1'b0);
            chk("mrst_idle_busy4", busy4, 1'b0);
        end
        do_start4(8'd0);
        frame4(1'b0, 16);

        // Default 32x32 frame with random pixels.
        for (int i = 0; i < 1024; i++) img[i] = 8'($urandom);
        wins32  = 0;
        dones32 = 0;
        start32 = 1'b1; valid32 = 1'b1; pix32 = 8'hFF;
        @(posedge clk); #1;
        start32 = 1'b0;
        chk("busy32_start", busy32, 1'b1);
        for (int i = 0; i < 1024; i++) begin
            valid32 = 1'b1;
            pix32   = img[i];
            @(posedge clk); #1;
            valid32 = 1'b0;
            r  = i / 32;
            c  = i % 32;
            ew = (r >= 2) && (c >= 2);
            if (wv32) wins32++;
            if (done32) dones32++;
            chk("valid32", wv32, ew);
            if (ew) begin
                for (int k = 0; k < 9; k++) begin
                    e[8*k +: 8] = img[(r - 2 + k / 3) * 32 + (c - 2 + k % 3)];
                end
                chk("win32", data32, e);
            end
        end
        chk("done32_last", done32, 1'b1);
        chk("busy32_end", busy32, 1'b0);
        for (int i = 0; i < 3; i++) begin
            valid32 = 1'b1;
            pix32   = 8'h5A;
            @(posedge clk); #1;
            valid32 = 1'b0;
            if (wv32) wins32++;
            if (done32) dones32++;
        end
        chk("count32", wins32, 900);
        chk("dones32", dones32, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
